// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps exactly one instruction-memory
// request in flight, and hands {pc, inst} to the IF/ID register over a
// valid/ready handshake. Redirects restart fetch at a new target and squash
// any wrong-path response that is still outstanding.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request for pc presented to memory, waiting for req handshake
// WAIT  | request accepted, waiting for the single response beat
// OUT   | instruction held in o_pc/o_inst, offered downstream
module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_inst
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [DATA_W-1:0] INST_NOP = DATA_W'(32'h0000_0013);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              kill;

    logic              req_fire;
    logic              out_fire;
    logic [ADDR_W-1:0] redirect_aligned;
    logic [ADDR_W-1:0] pc_next_seq;

    // Handshake qualifiers and address arithmetic. The request is masked by
    // rst_n so nothing is offered to memory while reset is held, even though
    // the state register already sits in REQ.
    always_comb begin
        imem_req_valid   = (state == ST_REQ) && rst_n;
        imem_req_addr    = pc;
        o_valid          = (state == ST_OUT) && !redirect_valid;
        req_fire         = imem_req_valid && imem_req_ready;
        out_fire         = o_valid && o_ready;
        redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
        pc_next_seq      = pc + ADDR_W'(4);
    end

    // Fetch FSM, PC and output registers. A redirect overrides every other
    // transition; kill remembers that the one outstanding request is now on
    // the wrong path so its response can be dropped when it lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_REQ;
            pc     <= ADDR_W'(RESET_ADDR);
            kill   <= 1'b0;
            o_pc   <= ADDR_W'(RESET_ADDR);
            o_inst <= INST_NOP;
        end else if (redirect_valid) begin
            pc <= redirect_aligned;
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        state <= ST_WAIT;
                        kill  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= ST_REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            o_inst <= imem_rsp_data;
                            o_pc   <= pc;
                            pc     <= pc_next_seq;
                            state  <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_fire) begin
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a per-cycle vector table of inputs and
// hand-computed outputs, plus a hand-written mid-fetch reset sequence.
module tb_ifu_fetch;

    localparam logic [31:0] R   = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;

    int total;
    int bad;

    ifu_fetch #(.RESET_ADDR(32'h8000_0000), .ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_pc           (o_pc),
        .o_inst         (o_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ordy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rqr, input logic rsv, input logic [31:0] rsd,
                       input logic ordy, input logic e_rqv, input logic [31:0] e_addr,
                       input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd;
        v.ordy = ordy; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_ov = e_ov;
        v.e_pc = e_pc; v.e_inst = e_inst;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic e_rqv, input logic [31:0] e_addr,
                              input logic e_ov, input logic [31:0] e_pc,
                              input logic [31:0] e_inst);
        chk("req_valid", idx, 32'(imem_req_valid), 32'(e_rqv));
        chk("req_addr",  idx, imem_req_addr, e_addr);
        chk("o_valid",   idx, 32'(o_valid), 32'(e_ov));
        chk("o_pc",      idx, o_pc, e_pc);
        chk("o_inst",    idx, o_inst, e_inst);
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                         input logic rqr, input logic rsv, input logic [31:0] rsd,
                         input logic ordy);
        rst_n = rst; redirect_valid = rv; redirect_pc = rpc; imem_req_ready = rqr;
        imem_rsp_valid = rsv; imem_rsp_data = rsd; o_ready = ordy;
    endtask

    initial begin
        logic [31:0] a [0:8];
        total = 0;
        bad   = 0;
        a[0] = 32'h0000_0093; a[1] = 32'h0010_0113; a[2] = 32'h0020_0193;
        a[3] = 32'h0030_0213; a[4] = 32'h0040_0293; a[5] = 32'h0050_0313;
        a[6] = 32'h0060_0393; a[7] = 32'h0070_0413; a[8] = 32'h0080_0493;

        //   rst rv rpc            rqr rsv rsd            ordy | rqv addr          ov o_pc          o_inst
        // reset held three cycles
        for (int i = 0; i < 3; i++)
            add(0, 0, 0,              0, 0, 0,             0,     0, R,            0, R,            NOP);
        // three sequential fetches, zero-wait memory, o_ready high
        add(1, 0, 0,              1, 0, 0,             1,     1, R,            0, R,            NOP);
        add(1, 0, 0,              1, 1, a[0],          1,     0, R,            0, R,            NOP);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+4,          1, R,            a[0]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+4,          0, R,            a[0]);
        add(1, 0, 0,              1, 1, a[1],          1,     0, R+4,          0, R,            a[0]);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+8,          1, R+4,          a[1]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+8,          0, R+4,          a[1]);
        add(1, 0, 0,              1, 1, a[2],          1,     0, R+8,          0, R+4,          a[1]);
        // downstream back-pressure for five cycles
        for (int i = 0; i < 5; i++)
            add(1, 0, 0,          1, 0, 0,             0,     0, R+12,         1, R+8,          a[2]);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+12,         1, R+8,          a[2]);
        // memory not ready for four cycles
        for (int i = 0; i < 4; i++)
            add(1, 0, 0,          0, 0, 0,             1,     1, R+12,         0, R+8,          a[2]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+12,         0, R+8,          a[2]);
        add(1, 0, 0,              1, 1, a[3],          1,     0, R+12,         0, R+8,          a[2]);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+16,         1, R+12,         a[3]);
        // redirect while waiting, late wrong-path response dropped
        add(1, 0, 0,              1, 0, 0,             1,     1, R+16,         0, R+12,         a[3]);
        add(1, 1, R+32'h100,      1, 0, 0,             1,     0, R+16,         0, R+12,         a[3]);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+32'h100,    0, R+12,         a[3]);
        add(1, 0, 0,              1, 1, 32'hDEAD_BEEF, 1,     0, R+32'h100,    0, R+12,         a[3]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+32'h100,    0, R+12,         a[3]);
        add(1, 0, 0,              1, 1, a[4],          1,     0, R+32'h100,    0, R+12,         a[3]);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+32'h104,    1, R+32'h100,    a[4]);
        // redirect coincident with response, unaligned target
        add(1, 0, 0,              1, 0, 0,             1,     1, R+32'h104,    0, R+32'h100,    a[4]);
        add(1, 1, R+32'h203,      1, 1, 32'h0BAD_0001, 1,     0, R+32'h104,    0, R+32'h100,    a[4]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+32'h200,    0, R+32'h100,    a[4]);
        add(1, 0, 0,              1, 1, a[5],          1,     0, R+32'h200,    0, R+32'h100,    a[4]);
        // redirect while presenting: o_valid suppressed, no transfer
        add(1, 1, R+32'h300,      1, 0, 0,             1,     0, R+32'h204,    0, R+32'h200,    a[5]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+32'h300,    0, R+32'h200,    a[5]);
        add(1, 0, 0,              1, 1, a[6],          1,     0, R+32'h300,    0, R+32'h200,    a[5]);
        add(1, 0, 0,              1, 0, 0,             1,     0, R+32'h304,    1, R+32'h300,    a[6]);
        // redirect with same-cycle request handshake, then PC wrap
        add(1, 1, 32'hFFFF_FFFC,  1, 0, 0,             1,     1, R+32'h304,    0, R+32'h300,    a[6]);
        add(1, 0, 0,              1, 1, 32'h0BAD_0002, 1,     0, 32'hFFFF_FFFC, 0, R+32'h300,   a[6]);
        add(1, 0, 0,              1, 0, 0,             1,     1, 32'hFFFF_FFFC, 0, R+32'h300,   a[6]);
        add(1, 0, 0,              1, 1, a[7],          1,     0, 32'hFFFF_FFFC, 0, R+32'h300,   a[6]);
        add(1, 0, 0,              1, 0, 0,             1,     0, 32'h0,        1, 32'hFFFF_FFFC, a[7]);
        add(1, 0, 0,              1, 0, 0,             1,     1, 32'h0,        0, 32'hFFFF_FFFC, a[7]);
        // back-to-back redirects in WAIT: last one wins
        add(1, 1, R+32'h400,      1, 0, 0,             1,     0, 32'h0,        0, 32'hFFFF_FFFC, a[7]);
        add(1, 1, R+32'h500,      1, 0, 0,             1,     0, R+32'h400,    0, 32'hFFFF_FFFC, a[7]);
        add(1, 0, 0,              1, 1, 32'h0BAD_0003, 1,     0, R+32'h500,    0, 32'hFFFF_FFFC, a[7]);
        add(1, 0, 0,              1, 0, 0,             1,     1, R+32'h500,    0, 32'hFFFF_FFFC, a[7]);

        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rqr,
                  vecs[i].rsv, vecs[i].rsd, vecs[i].ordy);
            #1;
            check_outs(i, vecs[i].e_rqv, vecs[i].e_addr, vecs[i].e_ov,
                       vecs[i].e_pc, vecs[i].e_inst);
        end

        // Mid-WAIT asynchronous reset: outputs must drop before any clock edge.
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(1000, 0, R, 0, R, NOP);
        @(negedge clk);
        #1;
        check_outs(1001, 0, R, 0, R, NOP);
        // Release, then redirect in REQ without a request handshake.
        @(negedge clk);
        drive(1, 1, R+32'h600, 0, 0, 0, 1);
        #1;
        check_outs(1002, 1, R, 0, R, NOP);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 1);
        #1;
        check_outs(1003, 1, R+32'h600, 0, R, NOP);
        @(negedge clk);
        drive(1, 0, 0, 1, 1, a[8], 1);
        #1;
        check_outs(1004, 0, R+32'h600, 0, R, NOP);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 1);
        #1;
        check_outs(1005, 0, R+32'h604, 1, R+32'h600, a[8]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage that owns the PC and issues one instruction-memory request at a time. It presents {pc, inst} to the IF/ID pipeline register through a valid/ready handshake. It accepts a redirect (branch/jump target) from later stages and discards any wrong-path response still in flight. Sits directly upstream of fetch_id: o_valid/o_ready/o_pc/o_inst connect to that block's i_valid/i_ready/fetch_pc/fetch_inst.

Parameters:
RESET_ADDR, 32'h8000_0000, PC value after reset (matches CPU_RESET_ADDR)
ADDR_W, 32, PC / memory address width (INST_ADDR_BUS)
DATA_W, 32, instruction width (INST_DATA_BUS)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset; single clock domain
redirect_valid  in  1  flush current fetch, restart at redirect_pc
redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  request address, always word aligned
imem_rsp_valid  in  1  response data valid (one cycle per accepted request)
imem_rsp_data  in  DATA_W  instruction word
o_valid  out  1  instruction available to IF/ID register
o_ready  in  1  IF/ID register accepts
o_pc  out  ADDR_W  PC of presented instruction
o_inst  out  DATA_W  presented instruction

Behaviour:
- Reset (async, rst_n=0): state=REQ, pc=RESET_ADDR, kill=0, o_pc=RESET_ADDR, o_inst=32'h0000_0013 (INST_NOP), o_valid=0, imem_req_valid=0 while rst_n low; first request issued the first cycle after release.
- At most one outstanding memory request. imem_rsp_valid is ignored in every state except WAIT.
- imem_req_valid=(state==REQ); imem_req_addr=pc. Once asserted, addr is held stable until handshake unless a redirect occurs.
- o_valid=(state==OUT) && !redirect_valid. o_pc/o_inst are registers, stable while in OUT.
- States:
  REQ: req handshake -> WAIT. No handshake -> stay.
  WAIT: rsp_valid && !kill -> capture o_inst=rsp_data, o_pc=pc, pc<=pc+4, -> OUT. rsp_valid && kill -> kill<=0, -> REQ. No rsp -> stay.
  OUT: o_valid && o_ready -> REQ. Otherwise hold.
- Redirect, highest priority, any state: pc<=redirect_pc&~3.
  REQ without handshake: stay REQ.
  REQ with same-cycle handshake: -> WAIT with kill<=1.
  WAIT without rsp: kill<=1, stay WAIT.
  WAIT with same-cycle rsp: response dropped, kill<=0, -> REQ.
  OUT: held instruction discarded (o_valid already low this cycle), -> REQ.
- Back-to-back redirects: last one wins. kill is a single bit because only one request is ever outstanding.
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- Minimum latency: 3 cycles per instruction (REQ, WAIT, OUT) with zero-wait memory; this block provides no throughput overlap.
- Reset mid-operation: returns to REQ immediately. The memory shares rst_n, so no pre-reset response may arrive after reset.

Test Plan:
1. Reset held 3 cycles, then released with memory always ready, rsp 1 cycle later, o_ready=1 -> imem_req_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. o_pc matches each address, o_inst = rsp_data, one o_valid pulse per instruction every 3 cycles.
2. o_ready held low 5 cycles while in OUT -> o_valid stays 1, o_pc/o_inst unchanged, no new imem request. Raise o_ready -> next request at pc+4.
3. imem_req_ready low 4 cycles -> req_valid held, addr stable. Then handshake proceeds normally.
4. Redirect to 0x8000_0100 while in WAIT, response arrives 2 cycles later with 0xDEADBEEF -> response dropped, no o_valid. Next request at 0x8000_0100.
5. Redirect to 0x8000_0203 in the same cycle as rsp_valid -> response dropped, next request at 0x8000_0200. Redirect while in OUT with o_ready=1 -> o_valid=0 that cycle, no transfer.
6. Redirect to 0xFFFF_FFFC, fetch completes -> next request address 0x0000_0000. Assert rst_n low during WAIT -> outputs return to reset values immediately, and fetch restarts at 0x8000_0000.
